// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the mips_32 multiply/divide unit.
//   MDU_WIDTH      default operand width (HI and LO are this wide)
//   MDU_OP_*       op codes presented by EX on the 2-bit op bus
//   MDU_IDLE..FIX  FSM state encodings of mult_div_unit
//   mdu_is_div     op selects a division (DIV/DIVU)
//   mdu_is_signed  op selects a signed operation (MULT/DIV)
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int MDU_WIDTH = 32;

   localparam logic [1:0] MDU_OP_MULT  = 2'b00;
   localparam logic [1:0] MDU_OP_MULTU = 2'b01;
   localparam logic [1:0] MDU_OP_DIV   = 2'b10;
   localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

   localparam logic [1:0] MDU_IDLE = 2'd0;
   localparam logic [1:0] MDU_PREP = 2'd1;
   localparam logic [1:0] MDU_CALC = 2'd2;
   localparam logic [1:0] MDU_FIX  = 2'd3;

   function automatic logic mdu_is_div(input logic [1:0] op);
      return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
   endfunction

   function automatic logic mdu_is_signed(input logic [1:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// ---------------------------------------------------------------------------
// mdu_step
// Combinational single-iteration datapath of the multiply/divide unit.
// The 2*WIDTH accumulator holds {upper, lower} halves.
//   Multiply (div_mode=0): shift-add. lower starts as the multiplier; if its
//     LSB is set the operand (multiplicand) is added into upper, then the
//     whole accumulator (with the add carry) shifts right one bit.
//   Divide (div_mode=1): restoring shift-subtract. lower starts as the
//     dividend, upper is the partial remainder. The accumulator shifts left
//     one bit, the operand (divisor) is trial-subtracted from the remainder,
//     and the quotient bit enters at the LSB.
// Ports
//   acc_in    in   2*WIDTH  current accumulator
//   operand   in   WIDTH    multiplicand or divisor magnitude
//   div_mode  in   1        0 = shift-add, 1 = restoring subtract
//   acc_out   out  2*WIDTH  accumulator after one iteration
// ---------------------------------------------------------------------------
module mdu_step
   import mips_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   input  logic               div_mode,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] add_val;
   logic             qbit;

   // Multiply: conditional add keeps its carry in bit WIDTH of sum, which
   // becomes the new MSB after the right shift.
   assign add_val = acc_in[0] ? operand : '0;
   assign sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, add_val};

   // Divide: after the left shift the partial remainder needs WIDTH+1 bits
   // (acc_in[2W-1:W-1]); a clear sign bit on the difference means it fits.
   assign diff = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
   assign qbit = ~diff[WIDTH];

   always_comb begin
      // NOTE: every output of a combinational block gets a value on every
      // path (default first), otherwise synthesis infers a latch.
      acc_out = {sum, acc_in[WIDTH-1:1]};
      if (div_mode) begin
         acc_out = {(qbit ? diff[WIDTH-1:0] : acc_in[2*WIDTH-2:WIDTH-1]),
                    acc_in[WIDTH-2:0], qbit};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle MULT/MULTU/DIV/DIVU engine beside the EX stage; owns HI/LO.
// An accepted op runs IDLE -> PREP -> CALC (WIDTH cycles) -> FIX -> IDLE, so
// HI/LO update and done pulses WIDTH+2 edges after the accepting edge.
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low reset
//   start     in   1      EX holds a mult/div op this cycle
//   op        in   2      MDU_OP_* code
//   rs_val    in   WIDTH  multiplicand / dividend
//   rt_val    in   WIDTH  multiplier / divisor
//   hilo_rd   in   1      MFHI/MFLO in EX
//   hi_we     in   1      MTHI: write wdata to HI
//   lo_we     in   1      MTLO: write wdata to LO
//   wdata     in   WIDTH  MTHI/MTLO data
//   flush     in   1      aborts an in-flight op
//   busy      out  1      op in flight
//   done      out  1      one-cycle pulse when HI/LO show a new result
//   stall     out  1      to hazard unit
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
// ---------------------------------------------------------------------------
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH      = MDU_WIDTH,
   parameter int ITER_CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hilo_rd,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [1:0]            state;
   logic [ITER_CNT_W-1:0] cnt;
   logic [2*WIDTH-1:0]    acc;
   logic [2*WIDTH-1:0]    acc_step;

   // Operation context latched when an op is accepted.
   logic                  div_q;       // division in flight
   logic                  neg_q;       // product / quotient must be negated
   logic                  rem_neg_q;   // remainder must be negated
   logic                  dvz_q;       // divisor was zero
   logic [WIDTH-1:0]      operand_q;   // multiplicand or divisor magnitude
   logic [WIDTH-1:0]      low_q;       // multiplier or dividend magnitude
   logic [WIDTH-1:0]      dividend_q;  // raw rs, returned in HI on divide-by-zero

   logic                  signed_op;
   logic                  rs_neg;
   logic                  rt_neg;
   logic [WIDTH-1:0]      rs_mag;
   logic [WIDTH-1:0]      rt_mag;

   logic [2*WIDTH-1:0]    prod;
   logic [WIDTH-1:0]      res_hi;
   logic [WIDTH-1:0]      res_lo;

   // The iteration works on magnitudes; signs are reapplied in FIX.
   // The magnitude of the most negative value is its own bit pattern, which
   // is correct when read as unsigned.
   assign signed_op = mdu_is_signed(op);
   assign rs_neg    = signed_op & rs_val[WIDTH-1];
   assign rt_neg    = signed_op & rt_val[WIDTH-1];
   assign rs_mag    = rs_neg ? -rs_val : rs_val;
   assign rt_mag    = rt_neg ? -rt_val : rt_val;

   assign busy  = (state != MDU_IDLE);
   assign stall = busy & (start | hilo_rd | hi_we | lo_we);

   mdu_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc_in   (acc),
      .operand  (operand_q),
      .div_mode (div_q),
      .acc_out  (acc_step)
   );

   // Sign correction and result mapping, consumed on the FIX edge.
   always_comb begin
      prod   = neg_q ? -acc : acc;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (div_q) begin
         if (dvz_q) begin
            res_lo = '1;
            res_hi = dividend_q;
         end else begin
            res_lo = neg_q     ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            res_hi = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
         end
      end
   end

   // NOTE: registers are updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= MDU_IDLE;
         cnt        <= '0;
         acc        <= '0;
         div_q      <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         dvz_q      <= 1'b0;
         operand_q  <= '0;
         low_q      <= '0;
         dividend_q <= '0;
         hi         <= '0;
         lo         <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            MDU_IDLE: begin
               if (start && !flush) begin
                  div_q      <= mdu_is_div(op);
                  operand_q  <= mdu_is_div(op) ? rt_mag : rs_mag;
                  low_q      <= mdu_is_div(op) ? rs_mag : rt_mag;
                  neg_q      <= rs_neg ^ rt_neg;
                  rem_neg_q  <= rs_neg;
                  dvz_q      <= (rt_val == '0);
                  dividend_q <= rs_val;
                  state      <= MDU_PREP;
               end else if (!start) begin
                  // A coinciding start (even a flushed one) drops MTHI/MTLO.
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            MDU_PREP: begin
               if (flush) begin
                  state <= MDU_IDLE;
                  cnt   <= '0;
               end else begin
                  acc   <= {{WIDTH{1'b0}}, low_q};
                  cnt   <= ITER_CNT_W'(WIDTH);
                  state <= MDU_CALC;
               end
            end
            MDU_CALC: begin
               if (flush) begin
                  state <= MDU_IDLE;
                  cnt   <= '0;
               end else begin
                  acc <= acc_step;
                  cnt <= cnt - ITER_CNT_W'(1);
                  if (cnt == ITER_CNT_W'(1)) state <= MDU_FIX;
               end
            end
            MDU_FIX: begin
               state <= MDU_IDLE;
               if (!flush) begin
                  hi   <= res_hi;
                  lo   <= res_lo;
                  done <= 1'b1;
               end
            end
            default: state <= MDU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. Each accepted op pushes the result
// of a plain-arithmetic reference model into a queue; a monitor pops and
// compares HI/LO whenever done pulses. Directed sequences check latency,
// busy/stall timing, flush, async reset and MTHI/MTLO, followed by random ops.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
   import mips_pkg::*;

   localparam int W = 32;

   logic         clk     = 1'b0;
   logic         reset   = 1'b0;
   logic         start   = 1'b0;
   logic [1:0]   op      = 2'b00;
   logic [W-1:0] rs_val  = '0;
   logic [W-1:0] rt_val  = '0;
   logic         hilo_rd = 1'b0;
   logic         hi_we   = 1'b0;
   logic         lo_we   = 1'b0;
   logic [W-1:0] wdata   = '0;
   logic         flush   = 1'b0;
   logic         busy;
   logic         done;
   logic         stall;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   res_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mult_div_unit #(
      .WIDTH      (W),
      .ITER_CNT_W (6)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .hilo_rd (hilo_rd),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .wdata   (wdata),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference model: MIPS semantics from 64-bit integer arithmetic.
   function automatic res_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t            r;
      longint          sa;
      longint          sb;
      longint          sp;
      longint unsigned up;
      r = '0;
      case (o)
         MDU_OP_MULT: begin
            sa = $signed(a);
            sb = $signed(b);
            sp = sa * sb;
            r.hi = sp[63:32];
            r.lo = sp[31:0];
         end
         MDU_OP_MULTU: begin
            up = {32'h0, a} * {32'h0, b};
            r.hi = up[63:32];
            r.lo = up[31:0];
         end
         MDU_OP_DIV: begin
            if (b == 0) begin
               r.lo = 32'hffffffff;
               r.hi = a;
            end else if (a == 32'h80000000 && b == 32'hffffffff) begin
               r.lo = 32'h80000000;
               r.hi = 32'h0;
            end else begin
               r.lo = $signed(a) / $signed(b);
               r.hi = $signed(a) % $signed(b);
            end
         end
         default: begin
            if (b == 0) begin
               r.lo = 32'hffffffff;
               r.hi = a;
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
      endcase
      return r;
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      res_t e;
      if (reset && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 with hi=0x%08h lo=0x%08h, expected no result", hi, lo);
         end else begin
            e = exp_q.pop_front();
            check("result_hi", hi, e.hi);
            check("result_lo", lo, e.lo);
         end
      end
   end

   // Presents an op for one accepting edge (caller ensures the unit is idle).
   // Returns at the negedge just after the accepting edge T.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit expect_result);
      @(negedge clk);
      op     = o;
      rs_val = a;
      rt_val = b;
      start  = 1'b1;
      if (expect_result) exp_q.push_back(model(o, a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
      end
      check({name, "_done_seen"}, {31'b0, done}, 1);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string name);
      issue(o, a, b, 1'b1);
      wait_done(name);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hffffffff;
         3:       return 32'h80000000;
         4:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      logic [W-1:0] snap_hi;
      logic [W-1:0] snap_lo;

      // Reset state
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_stall", {31'b0, stall}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // MULT x 1: latency and busy window
      issue(MDU_OP_MULT, 32'h0fd76e10, 32'h1, 1'b1);
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (k <= 33) check($sformatf("mult_busy_T%0d", k), {31'b0, busy}, 1);
         if (k == 33) check("mult_done_early", {31'b0, done}, 0);
         if (k == 34) begin
            check("mult_busy_end", {31'b0, busy}, 0);
            check("mult_done_T34", {31'b0, done}, 1);
         end
         if (k == 35) check("mult_done_pulse", {31'b0, done}, 0);
      end

      // DIV / 1 with MFHI pending from T+5: stall window
      issue(MDU_OP_DIV, 32'h0fd76e10, 32'h1, 1'b1);
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         if (k == 3) check("stall_no_req", {31'b0, stall}, 0);
         if (k >= 5 && k <= 33) check($sformatf("stall_T%0d", k), {31'b0, stall}, 1);
         if (k == 34) begin
            check("stall_T34", {31'b0, stall}, 0);
            check("div1_done_T34", {31'b0, done}, 1);
         end
         if (k == 4) hilo_rd = 1'b1;
      end
      hilo_rd = 1'b0;

      // Boundary results
      run_op(MDU_OP_DIV,   32'hfffffff9, 32'h2,        "div_m7_2");
      run_op(MDU_OP_MULTU, 32'hffffffff, 32'hffffffff, "multu_max");
      run_op(MDU_OP_DIVU,  32'h1234,     32'h0,        "divu_by0");
      run_op(MDU_OP_DIV,   32'h80000000, 32'hffffffff, "div_ovf");
      run_op(MDU_OP_DIV,   32'hfffffff9, 32'h0,        "div_by0_neg");
      run_op(MDU_OP_MULT,  32'h80000000, 32'h80000000, "mult_min");

      // Flush mid-op: abort, HI/LO untouched, no done
      snap_hi = hi;
      snap_lo = lo;
      issue(MDU_OP_MULT, 32'h5, 32'h6, 1'b0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 0);
      repeat (40) @(negedge clk);
      check("flush_hi", hi, snap_hi);
      check("flush_lo", lo, snap_lo);

      // Async reset mid-op
      issue(MDU_OP_DIV, 32'h7fff0000, 32'h3, 1'b0);
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      check("amid_rst_hi", hi, 0);
      check("amid_rst_lo", lo, 0);
      check("amid_rst_busy", {31'b0, busy}, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_lo", lo, 0);

      // MTHI / MTLO while idle
      hi_we = 1'b1;
      wdata = 32'hdeadbeef;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi_hi", hi, 32'hdeadbeef);
      check("mthi_lo", lo, 0);
      lo_we = 1'b1;
      wdata = 32'h13579bdf;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo_lo", lo, 32'h13579bdf);

      // start and MTLO coincide: the write is dropped
      op     = MDU_OP_MULTU;
      rs_val = 32'h3;
      rt_val = 32'h5;
      start  = 1'b1;
      lo_we  = 1'b1;
      wdata  = 32'ha5a5a5a5;
      exp_q.push_back(model(MDU_OP_MULTU, 32'h3, 32'h5));
      @(negedge clk);
      start = 1'b0;
      lo_we = 1'b0;
      check("start_wins_lo", lo, 32'h13579bdf);
      check("start_wins_busy", {31'b0, busy}, 1);
      wait_done("start_wins");

      // No stall while idle
      hilo_rd = 1'b1;
      #1;
      check("idle_no_stall", {31'b0, stall}, 0);
      hilo_rd = 1'b0;

      // flush with start: not accepted
      @(negedge clk);
      op     = MDU_OP_MULT;
      rs_val = 32'h2;
      rt_val = 32'h3;
      start  = 1'b1;
      flush  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush_start_busy", {31'b0, busy}, 0);
      repeat (40) @(negedge clk);

      // start while busy: stalled and ignored
      issue(MDU_OP_MULTU, 32'h7, 32'h9, 1'b1);
      repeat (3) @(negedge clk);
      op     = MDU_OP_DIVU;
      rs_val = 32'd100;
      rt_val = 32'd3;
      start  = 1'b1;
      #1;
      check("busy_start_stall", {31'b0, stall}, 1);
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start");
      repeat (40) @(negedge clk);

      // Random ops against the reference model
      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(0, 3)), pick(), pick(), $sformatf("rnd%0d", i));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", W'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
